// File: rtl/pipe_addsub_pkg.sv
// Shared constants and parameter-legality helpers for the pipelined adder/subtractor.
package pipe_addsub_pkg;

  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_STAGES = 4;
  localparam int unsigned SLICE_W    = DEF_WIDTH / DEF_STAGES;

  // Bits handled by one pipeline segment.
  function automatic int unsigned slice_w(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

  // Legal configuration: WIDTH >= 2, 1 <= STAGES <= WIDTH, WIDTH evenly split.
  function automatic bit params_ok(input int unsigned width, input int unsigned stages);
    return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational SW-bit ripple add of one operand slice, with carry and MSB carry-in.
module addsub_slice
  import pipe_addsub_pkg::*;
#(
  parameter int unsigned SW = SLICE_W
) (
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] b_i,
  input  logic          c_i,
  output logic [SW-1:0] sum_c_o,
  output logic          cout_c_o,
  output logic          msb_cin_c_o
);

  logic [SW:0] full_c;

  // One extra bit catches the carry out of the slice.
  assign full_c      = {1'b0, a_i} + {1'b0, b_i} + (SW+1)'(c_i);
  assign sum_c_o     = full_c[SW-1:0];
  assign cout_c_o    = full_c[SW];
  // Carry into the slice MSB recovered from the MSB sum bit.
  assign msb_cin_c_o = a_i[SW-1] ^ b_i[SW-1] ^ full_c[SW-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: STAGES carry-registered slices with
// skewed operand/sum registers, valid/ready handshake and global stall.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SW = slice_w(WIDTH, STAGES);

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipe_addsub: illegal WIDTH/STAGES combination");
  end

  // Per-stage register outputs, visible to the following stage.
  logic             stg_v [STAGES];
  logic             stg_c [STAGES];
  logic             stg_o [STAGES];
  logic [WIDTH-1:0] stg_a [STAGES];
  logic [WIDTH-1:0] stg_b [STAGES];
  logic [WIDTH-1:0] stg_s [STAGES];

  // Whole pipe advances together whenever the output slot can move.
  assign in_ready  = !out_valid || out_ready;
  assign out_valid = stg_v[STAGES-1];
  assign sum       = stg_s[STAGES-1];
  assign cout      = stg_c[STAGES-1];
  assign ovf       = stg_o[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_in, c_in;
    logic [WIDTH-1:0] a_in, b_in, s_in;
    logic [SW-1:0]    sl_sum;
    logic             sl_cout, sl_msb;
    logic             v_q, v_d, c_q, c_d, o_q, o_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;

    if (k == 0) begin : g_head
      // Subtract becomes a + ~b + 1; cin only matters when adding.
      assign v_in = in_valid;
      assign a_in = a;
      assign b_in = sub ? ~b : b;
      assign c_in = sub ? 1'b1 : cin;
      assign s_in = '0;
    end else begin : g_body
      assign v_in = stg_v[k-1];
      assign a_in = stg_a[k-1];
      assign b_in = stg_b[k-1];
      assign c_in = stg_c[k-1];
      assign s_in = stg_s[k-1];
    end

    addsub_slice #(.SW(SW)) u_slice (
      .a_i        (a_in[SW-1:0]),
      .b_i        (b_in[SW-1:0]),
      .c_i        (c_in),
      .sum_c_o    (sl_sum),
      .cout_c_o   (sl_cout),
      .msb_cin_c_o(sl_msb)
    );

    // Next state: hold on stall, else consume lowest operand slice and push sum slice in at the top.
    always_comb begin
      v_d = v_q;
      c_d = c_q;
      o_d = o_q;
      a_d = a_q;
      b_d = b_q;
      s_d = s_q;
      if (in_ready) begin
        v_d = v_in;
        c_d = sl_cout;
        o_d = sl_msb ^ sl_cout;
        a_d = a_in >> SW;
        b_d = b_in >> SW;
        s_d = (s_in >> SW) | (WIDTH'(sl_sum) << (WIDTH - SW));
      end
    end

    // Stage register with async clear of valid and datapath.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        o_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
      end else begin
        v_q <= v_d;
        c_q <= c_d;
        o_q <= o_d;
        a_q <= a_d;
        b_q <= b_d;
        s_q <= s_d;
      end
    end

    assign stg_v[k] = v_q;
    assign stg_c[k] = c_q;
    assign stg_o[k] = o_q;
    assign stg_a[k] = a_q;
    assign stg_b[k] = b_q;
    assign stg_s[k] = s_q;
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub: directed table, stall/reset sequences,
// and randomized traffic on STAGES=4, 1 and 16 instances against a behavioural model.
module tb_pipe_addsub;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic         iv [3];
  logic         ir [3];
  logic         ov [3];
  logic         ordy [3];
  logic         ci [3];
  logic         sb [3];
  logic         co [3];
  logic         of [3];
  logic [W-1:0] av [3];
  logic [W-1:0] bv [3];
  logic [W-1:0] sm [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(16), .STAGES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(av[0]), .b(bv[0]),
    .cin(ci[0]), .sub(sb[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sm[0]),
    .cout(co[0]), .ovf(of[0]));

  pipe_addsub #(.WIDTH(16), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1]), .b(bv[1]),
    .cin(ci[1]), .sub(sb[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sm[1]),
    .cout(co[1]), .ovf(of[1]));

  pipe_addsub #(.WIDTH(16), .STAGES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(av[2]), .b(bv[2]),
    .cin(ci[2]), .sub(sb[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sm[2]),
    .cout(co[2]), .ovf(of[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on the operands.
  function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    vec_t v;
    logic [W:0] u;
    logic signed [W-1:0] sa, sbb;
    int r;
    sa = a;
    sbb = b;
    v.a = a; v.b = b; v.cin = cin; v.sub = sub;
    if (sub) begin
      v.sum  = a - b;
      v.cout = (a >= b);
      r = int'(sa) - int'(sbb);
    end else begin
      u = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      v.sum  = u[W-1:0];
      v.cout = u[W];
      r = int'(sa) + int'(sbb) + (cin ? 1 : 0);
    end
    v.ovf = (r > 32767) || (r < -32768);
    return v;
  endfunction

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                              input logic sub, input logic [W-1:0] s, input logic c, input logic o);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.sub = sub; v.sum = s; v.cout = c; v.ovf = o;
    return v;
  endfunction

  task automatic drive(input int k, input vec_t v);
    av[k] = v.a; bv[k] = v.b; ci[k] = v.cin; sb[k] = v.sub;
  endtask

  // Single isolated transaction: checks latency and the result.
  task automatic one_txn(input int k, input vec_t v, input int lat, input string tag);
    int n;
    @(negedge clk);
    ordy[k] = 1'b1;
    iv[k] = 1'b1;
    drive(k, v);
    #1 check({tag, " in_ready"}, 32'(ir[k]), 32'd1);
    @(negedge clk);
    iv[k] = 1'b0;
    n = 1;
    while (!ov[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " sum"}, 32'(sm[k]), 32'(v.sum));
    check({tag, " cout"}, 32'(co[k]), 32'(v.cout));
    check({tag, " ovf"}, 32'(of[k]), 32'(v.ovf));
  endtask

  // Random traffic with random back-pressure, scoreboarded against the model.
  task automatic run_rand(input int k, input int n, input string tag);
    vec_t q[$];
    vec_t v, e;
    int sent, got;
    bit pend, stalled;
    logic [W+1:0] held;
    sent = 0; got = 0; pend = 0; stalled = 0; held = '0;
    v = model('0, '0, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 20000 && got < n; cyc++) begin
      @(negedge clk);
      ordy[k] = ($urandom_range(0, 9) < 7);
      if (!pend) begin
        if (sent < n && $urandom_range(0, 3) != 0) begin
          v = model(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
          drive(k, v);
          iv[k] = 1'b1;
          pend = 1;
        end else begin
          iv[k] = 1'b0;
        end
      end
      #1;
      if (stalled) check({tag, " stall hold"}, 32'({ov[k], co[k], of[k], sm[k]}), 32'({1'b1, held}));
      stalled = ov[k] && !ordy[k];
      if (stalled) held = {co[k], of[k], sm[k]};
      if (iv[k] && ir[k]) begin
        q.push_back(v);
        sent++;
        pend = 0;
      end
      if (ov[k] && ordy[k]) begin
        if (q.size() == 0) begin
          check({tag, " unexpected result"}, 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check({tag, " result"}, 32'({co[k], of[k], sm[k]}), 32'({e.cout, e.ovf, e.sum}));
        end
        got++;
      end
    end
    iv[k] = 1'b0;
    ordy[k] = 1'b1;
    check({tag, " results received"}, 32'(got), 32'(n));
  endtask

  vec_t tbl [8];
  vec_t sv [8];

  initial begin
    int idx, got, stall_left, highs, n;
    bit stall_done;
    logic [W-1:0] held_sum;
    vec_t e;

    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b1; av[k] = '0; bv[k] = '0; ci[k] = 1'b0; sb[k] = 1'b0;
    end

    tbl[0] = mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    tbl[1] = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    tbl[2] = mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    tbl[3] = mk(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    tbl[4] = mk(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    tbl[5] = mk(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    tbl[6] = mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    tbl[7] = mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Reset state on every instance.
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset out_valid[%0d]", k), 32'(ov[k]), 32'd0);
      check($sformatf("reset outputs[%0d]", k), 32'({co[k], of[k], sm[k]}), 32'd0);
      check($sformatf("reset in_ready[%0d]", k), 32'(ir[k]), 32'd1);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table on STAGES=4.
    for (int i = 0; i < 8; i++) one_txn(0, tbl[i], 4, $sformatf("tbl%0d", i));

    // Latency of the extreme configurations.
    one_txn(1, tbl[1], 1, "s1 lat");
    one_txn(1, tbl[3], 1, "s1 sub");
    one_txn(2, tbl[2], 16, "s16 lat");
    one_txn(2, tbl[0], 16, "s16 carry");

    // Eight back-to-back transactions, output stalled for 3 cycles at first result.
    for (int i = 0; i < 8; i++)
      sv[i] = model(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    idx = 0; got = 0; stall_left = 0; stall_done = 0; held_sum = '0;
    for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
      @(negedge clk);
      if (!stall_done && ov[0]) begin
        stall_done = 1;
        stall_left = 3;
        held_sum = sm[0];
      end
      ordy[0] = (stall_left == 0);
      iv[0] = (idx < 8);
      if (idx < 8) drive(0, sv[idx]);
      #1;
      if (stall_left > 0) begin
        check("stall in_ready", 32'(ir[0]), 32'd0);
        check("stall out hold", 32'({ov[0], sm[0]}), 32'({1'b1, held_sum}));
        stall_left--;
      end
      if (iv[0] && ir[0]) idx++;
      if (ov[0] && ordy[0]) begin
        if (got < 8) begin
          e = sv[got];
          check($sformatf("stall seq result %0d", got), 32'({co[0], of[0], sm[0]}),
                32'({e.cout, e.ovf, e.sum}));
        end
        got++;
      end
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    check("stall seq count", 32'(got), 32'd8);
    check("stall seq stalled", 32'(stall_done), 32'd1);

    // Reset with three transactions in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      iv[0] = 1'b1;
      drive(0, model(16'($urandom), 16'($urandom), 1'b0, 1'b0));
    end
    @(negedge clk);
    iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pre-reset out_valid", 32'(ov[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid reset out_valid", 32'(ov[0]), 32'd0);
    check("mid reset outputs", 32'({co[0], of[0], sm[0]}), 32'd0);
    check("mid reset in_ready", 32'(ir[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ov[0]) highs++;
    end
    check("post reset ghost results", 32'(highs), 32'd0);
    one_txn(0, tbl[4], 4, "post reset");

    // Concurrent randomized traffic on all three configurations.
    fork
      run_rand(0, 1000, "rand s4");
      run_rand(1, 1000, "rand s1");
      run_rand(2, 1000, "rand s16");
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
